operand_loader: RTL and testbench

Serial writer that fills the convolution operand store: accepts a 25-byte frame over a valid/ready byte stream and writes it into the 4x4 input-tile registers (a00..a33) and the 3x3 filter registers (b00..b22). Its parallel outputs have the same names and widths as the operand-store outputs, so it drives the systolic array directly and replaces the hard-wired initial values with runtime-loadable data. A load is kicked off by a start pulse; completion is flagged by load_done.

---
 rtl/conv_pkg.sv | 22 ++
 rtl/operand_regfile.sv | 39 +++
 rtl/operand_loader.sv | 98 +++++++++
 tb/tb_operand_loader.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution operand path: operand sizes and the
// loader state encoding reused by readback/result blocks.
package conv_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned A_DIM  = 4;
    localparam int unsigned K_DIM  = 3;
    localparam int unsigned A_CNT  = A_DIM * A_DIM;
    localparam int unsigned K_CNT  = K_DIM * K_DIM;
    localparam int unsigned OP_CNT = A_CNT + K_CNT;
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned SEL_W  = 5;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        DONE   = 3'd3,
        ERR    = 3'd4
    } load_state_e;

endpackage

// File: rtl/operand_regfile.sv
// Operand store: 25 write-enabled byte registers, a00..a33 then b00..b22,
// selected by a one-hot write enable.
module operand_regfile
    import conv_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [OP_CNT-1:0] i_we,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] a00, a01, a02, a03,
    output logic [DATA_W-1:0] a10, a11, a12, a13,
    output logic [DATA_W-1:0] a20, a21, a22, a23,
    output logic [DATA_W-1:0] a30, a31, a32, a33,
    output logic [DATA_W-1:0] b00, b01, b02,
    output logic [DATA_W-1:0] b10, b11, b12,
    output logic [DATA_W-1:0] b20, b21, b22
);

    logic [DATA_W-1:0] r_q [OP_CNT];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < OP_CNT; i++) r_q[i] <= '0;
        end else begin
            for (int i = 0; i < OP_CNT; i++) begin
                if (i_we[i]) r_q[i] <= i_wdata;
            end
        end
    end

    assign {a00, a01, a02, a03} = {r_q[0],  r_q[1],  r_q[2],  r_q[3]};
    assign {a10, a11, a12, a13} = {r_q[4],  r_q[5],  r_q[6],  r_q[7]};
    assign {a20, a21, a22, a23} = {r_q[8],  r_q[9],  r_q[10], r_q[11]};
    assign {a30, a31, a32, a33} = {r_q[12], r_q[13], r_q[14], r_q[15]};
    assign {b00, b01, b02}      = {r_q[16], r_q[17], r_q[18]};
    assign {b10, b11, b12}      = {r_q[19], r_q[20], r_q[21]};
    assign {b20, b21, b22}      = {r_q[22], r_q[23], r_q[24]};

endmodule

// File: rtl/operand_loader.sv
// Serial loader: takes a 25-byte valid/ready frame (16 tile bytes, then 9
// filter bytes) into the operand store, with a framing check on in_last.
module operand_loader
    import conv_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic [DATA_W-1:0] a00, a01, a02, a03,
    output logic [DATA_W-1:0] a10, a11, a12, a13,
    output logic [DATA_W-1:0] a20, a21, a22, a23,
    output logic [DATA_W-1:0] a30, a31, a32, a33,
    output logic [DATA_W-1:0] b00, b01, b02,
    output logic [DATA_W-1:0] b10, b11, b12,
    output logic [DATA_W-1:0] b20, b21, b22,
    output logic              load_busy,
    output logic              load_done,
    output logic              frame_err
);

    load_state_e       r_state;
    logic [IDX_W-1:0]  r_idx;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic              w_loading;
    logic              w_beat;
    logic              w_final;
    logic [SEL_W-1:0]  w_sel;
    logic [OP_CNT-1:0] w_we;

    // start wins over a beat in the same cycle, so ready is masked by it
    assign w_loading = (r_state == LOAD_A) || (r_state == LOAD_B);
    assign in_ready  = w_loading & ~start;
    assign w_beat    = in_valid & in_ready;
    assign w_final   = (r_state == LOAD_B) && (r_idx == IDX_W'(K_CNT - 1));

    always_comb begin
        w_sel = SEL_W'(r_idx);
        if (r_state == LOAD_B) w_sel = SEL_W'(A_CNT) + SEL_W'(r_idx);
        w_we = w_beat ? (OP_CNT'(1) << w_sel) : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else if (start) begin
            r_state <= LOAD_A;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else if (w_beat) begin
            // in_last must coincide exactly with the 25th beat
            if (in_last != w_final) begin
                r_state <= ERR;
                r_busy  <= 1'b0;
                r_err   <= 1'b1;
            end else if (w_final) begin
                r_state <= DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
            end else if ((r_state == LOAD_A) && (r_idx == IDX_W'(A_CNT - 1))) begin
                r_state <= LOAD_B;
                r_idx   <= '0;
            end else begin
                r_idx <= r_idx + IDX_W'(1);
            end
        end
    end

    assign load_busy = r_busy;
    assign load_done = r_done;
    assign frame_err = r_err;

    operand_regfile u_regfile (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_we),
        .i_wdata (in_data),
        .a00(a00), .a01(a01), .a02(a02), .a03(a03),
        .a10(a10), .a11(a11), .a12(a12), .a13(a13),
        .a20(a20), .a21(a21), .a22(a22), .a23(a23),
        .a30(a30), .a31(a31), .a32(a32), .a33(a33),
        .b00(b00), .b01(b01), .b02(b02),
        .b10(b10), .b11(b11), .b12(b12),
        .b20(b20), .b21(b21), .b22(b22)
    );

endmodule

// File: tb/tb_operand_loader.sv
// Self-checking bench for operand_loader: directed framing scenarios plus
// randomized frames against a flat beat-position reference model.
module tb_operand_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, in_valid, in_last;
    logic [7:0] in_data;
    logic       in_ready, load_busy, load_done, frame_err;
    logic [7:0] a00, a01, a02, a03, a10, a11, a12, a13;
    logic [7:0] a20, a21, a22, a23, a30, a31, a32, a33;
    logic [7:0] b00, b01, b02, b10, b11, b12, b20, b21, b22;

    operand_loader dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .a00(a00), .a01(a01), .a02(a02), .a03(a03),
        .a10(a10), .a11(a11), .a12(a12), .a13(a13),
        .a20(a20), .a21(a21), .a22(a22), .a23(a23),
        .a30(a30), .a31(a31), .a32(a32), .a33(a33),
        .b00(b00), .b01(b01), .b02(b02),
        .b10(b10), .b11(b11), .b12(b12),
        .b20(b20), .b21(b21), .b22(b22),
        .load_busy(load_busy), .load_done(load_done), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int t_start = 0;
    int t_done = -1;

    // Reference model: a frame is a flat sequence of 25 positions
    logic [7:0] m_ops [25];
    logic       m_busy, m_done, m_err;
    int         m_pos;
    logic [7:0] fr [25];

    task automatic chk(input string tag, input logic [199:0] got, input logic [199:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [199:0] dut_ops();
        return {a00, a01, a02, a03, a10, a11, a12, a13, a20, a21, a22, a23,
                a30, a31, a32, a33, b00, b01, b02, b10, b11, b12, b20, b21, b22};
    endfunction

    function automatic logic [199:0] model_ops();
        logic [199:0] v;
        for (int i = 0; i < 25; i++) v[(24 - i) * 8 +: 8] = m_ops[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 25; i++) m_ops[i] = 8'h00;
        m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0; m_pos = 0;
    endtask

    task automatic model_step(input logic s, input logic v, input logic [7:0] d, input logic l);
        if (s) begin
            m_busy = 1'b1; m_done = 1'b0; m_err = 1'b0; m_pos = 0;
        end else if (m_busy && v) begin
            m_ops[m_pos] = d;
            if (l != (m_pos == 24)) begin
                m_err = 1'b1; m_busy = 1'b0;
            end else if (m_pos == 24) begin
                m_done = 1'b1; m_busy = 1'b0;
            end else begin
                m_pos++;
            end
        end
    endtask

    // One clock: drive at negedge, check ready, advance model, check outputs
    task automatic tick(input logic s, input logic v, input logic [7:0] d, input logic l);
        start = s; in_valid = v; in_data = d; in_last = l;
        #1;
        chk("in_ready", in_ready, m_busy & ~s);
        @(posedge clk);
        cyc++;
        model_step(s, v, d, l);
        if (s) begin t_start = cyc; t_done = -1; end
        @(negedge clk);
        if (load_done && t_done < 0) t_done = cyc;
        chk("load_busy", load_busy, m_busy);
        chk("load_done", load_done, m_done);
        chk("frame_err", frame_err, m_err);
        chk("operands", dut_ops(), model_ops());
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(1'b0, 1'b0, 8'($urandom), 1'($urandom));
    endtask

    task automatic send_frame(input int last_pos, input int stall_every, input int stall_len,
                              input bit rnd_gap, input int stop_after);
        for (int i = 0; i < 25 && i < stop_after; i++) begin
            tick(1'b0, 1'b1, fr[i], 1'((i + 1) == last_pos));
            if (stall_every != 0 && ((i + 1) % stall_every) == 0) idle(stall_len);
            if (rnd_gap) idle(int'($urandom_range(0, 2)));
        end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
        model_reset();
        @(negedge clk); @(negedge clk);
        chk("rst_ops", dut_ops(), 200'h0);
        chk("rst_ready", in_ready, 1'b0);
        chk("rst_flags", {load_busy, load_done, frame_err}, 3'b000);
        rst = 1'b1;
        idle(2);

        // Full-rate load
        fr = '{8'd4, 8'd6, 8'd5, 8'd1, 8'd1, 8'd2, 8'd3, 8'd4, 8'd7, 8'd8, 8'd9, 8'd3, 8'd5,
               8'd7, 8'd2, 8'd7, 8'd2, 8'd3, 8'd2, 8'd4, 8'd6, 8'd5, 8'd1, 8'd7, 8'd1};
        tick(1'b1, 1'b0, 8'h00, 1'b0);
        send_frame(25, 0, 0, 1'b0, 25);
        chk("done_latency", 200'(t_done - t_start + 1), 200'd26);
        chk("a00", a00, 8'd4); chk("a13", a13, 8'd4); chk("a33", a33, 8'd7);
        chk("b00", b00, 8'd2); chk("b21", b21, 8'd7); chk("b22", b22, 8'd1);
        chk("full_err", frame_err, 1'b0);
        idle(2);

        // Stalled source: 3 idle cycles after every 4th byte
        tick(1'b1, 1'b0, 8'h00, 1'b0);
        send_frame(25, 4, 3, 1'b0, 25);
        chk("stall_a13", a13, 8'd4); chk("stall_b22", b22, 8'd1);
        chk("stall_done", load_done, 1'b1);
        idle(2);

        // Early in_last on beat 10
        for (int i = 0; i < 25; i++) fr[i] = 8'(8'h80 + i);
        tick(1'b1, 1'b0, 8'h00, 1'b0);
        send_frame(10, 0, 0, 1'b0, 10);
        chk("early_err", frame_err, 1'b1);
        chk("early_ready", in_ready, 1'b0);
        chk("early_a21", a21, 8'h89);
        chk("early_a22_kept", a22, 8'd9);
        chk("early_b22_kept", b22, 8'd1);
        chk("early_done", load_done, 1'b0);
        idle(3);

        // Missing in_last on beat 25
        tick(1'b1, 1'b0, 8'h00, 1'b0);
        send_frame(0, 0, 0, 1'b0, 25);
        chk("miss_err", frame_err, 1'b1);
        chk("miss_done", load_done, 1'b0);
        chk("miss_b22", b22, 8'h98);
        idle(2);

        // Restart after 12 beats, byte offered alongside start is dropped
        tick(1'b1, 1'b0, 8'h00, 1'b0);
        send_frame(25, 0, 0, 1'b0, 12);
        for (int i = 0; i < 25; i++) fr[i] = 8'h11;
        tick(1'b1, 1'b1, 8'hAA, 1'b0);
        send_frame(25, 0, 0, 1'b0, 25);
        chk("restart_ops", dut_ops(), {25{8'h11}});
        chk("restart_done", load_done, 1'b1);
        idle(2);

        // Async reset in the middle of beat 20
        for (int i = 0; i < 25; i++) fr[i] = 8'($urandom);
        tick(1'b1, 1'b0, 8'h00, 1'b0);
        send_frame(25, 0, 0, 1'b0, 19);
        in_valid = 1'b1; in_data = fr[19]; in_last = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("arst_ops", dut_ops(), 200'h0);
        chk("arst_ready", in_ready, 1'b0);
        chk("arst_flags", {load_busy, load_done, frame_err}, 3'b000);
        model_reset();
        @(posedge clk); cyc++;
        @(negedge clk);
        rst = 1'b1;
        idle(1);
        tick(1'b1, 1'b0, 8'h00, 1'b0);
        send_frame(25, 0, 0, 1'b0, 25);
        chk("arst_reload_done", load_done, 1'b1);
        idle(1);

        // Randomized frames: random data, gaps, framing errors and restarts
        for (int r = 0; r < 12; r++) begin
            int lp;
            int stop;
            for (int i = 0; i < 25; i++) fr[i] = 8'($urandom);
            lp = ($urandom_range(0, 3) != 0) ? 25 : int'($urandom_range(0, 24));
            stop = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 24)) : 25;
            tick(1'b1, 1'($urandom), 8'($urandom), 1'($urandom));
            send_frame(lp, 0, 0, 1'b1, stop);
            idle(int'($urandom_range(1, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
